// File: rtl/addsub_pkg.sv
// Shared opcodes, FSM encodings and result-entry width for the add/sub accumulator sequencer.
// Constants only, so there is no latency and no backpressure.
package addsub_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Result entry layout, MSB first: {ovf, zero, carry, result[3:0]}
    localparam int RES_W = 7;

endpackage

// File: rtl/addsub_result_fifo.sv
// Circular result FIFO: a push is written in 1 cycle and the head is shown combinationally from storage.
// A push is ignored when full and a pop is ignored when empty; push and pop together leave count unchanged.
module addsub_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_bit_adder_subtractor.sv
// 4-bit ripple adder/subtractor: Result = A + (B ^ {4{mode}}) + mode, with raw carry out.
// Purely combinational, so there is no latency and no backpressure.
module four_bit_adder_subtractor (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       mode,
    output logic [3:0] Result,
    output logic       Cout
);

    logic [3:0] b_x;

    assign b_x = B ^ {4{mode}};
    assign {Cout, Result} = {1'b0, A} + {1'b0, b_x} + {4'b0, mode};

endmodule

// File: rtl/addsub_accum_sequencer.sv
// Command-driven 4-bit accumulator feeding four_bit_adder_subtractor; one command per 2 cycles, result pushed 1 cycle after accept.
// in_ready drops in EXEC and whenever the result FIFO is full; out_ready back-pressure never disturbs acc.
module addsub_accum_sequencer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [3:0] in_operand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_carry,
    output logic       out_ovf,
    output logic       out_zero,
    output logic [3:0] acc
);

    import addsub_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       op_q;
    logic [3:0]       operand_q;
    logic             mode;
    logic [3:0]       b_in;
    logic [3:0]       sum;
    logic             cout;
    logic [3:0]       res;
    logic             carry;
    logic             ovf;
    logic             push;
    logic             pop;
    logic             accept;
    logic [RES_W-1:0] head;
    logic [CW-1:0]    count;

    assign accept = in_valid && in_ready;
    assign mode   = (op_q == OP_SUB);
    assign b_in   = operand_q ^ {4{mode}};

    four_bit_adder_subtractor u_adder (
        .A      (acc),
        .B      (operand_q),
        .mode   (mode),
        .Result (sum),
        .Cout   (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_LOAD;
            operand_q <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                op_q      <= in_op;
                operand_q <= in_operand;
            end
            if (push) begin
                acc <= res;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        push       = 1'b0;
        res        = acc;
        carry      = 1'b0;
        ovf        = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst && (count < CW'(FIFO_DEPTH));
                if (in_valid && in_ready) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                push       = 1'b1;
                state_next = ST_IDLE;
                case (op_q)
                    OP_LOAD: res = operand_q;
                    OP_ADD, OP_SUB: begin
                        res   = sum;
                        carry = cout;
                        ovf   = (acc[3] == b_in[3]) && (sum[3] != acc[3]);
                    end
                    default: res = '0;
                endcase
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The IDLE gate on count guarantees this push always finds a free slot.
    addsub_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ovf, (res == 4'h0), carry, res}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign out_result = head[3:0];
    assign out_carry  = head[4];
    assign out_zero   = head[5];
    assign out_ovf    = head[6];

endmodule

// File: tb/tb_addsub_accum_sequencer.sv
// Scenario bench for addsub_accum_sequencer: a mod-16 reference model queues expected entries on each accept,
// and every FIFO pop is compared against the head of that queue.
module tb_addsub_accum_sequencer;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] AD = 2'b01;
    localparam logic [1:0] SB = 2'b10;
    localparam logic [1:0] CL = 2'b11;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_operand;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_ovf;
    logic       out_zero;
    logic [3:0] acc;

    int         checks;
    int         errors;
    int         pops;
    logic       rand_en;
    logic [3:0] m_acc;
    logic [6:0] exp_q[$];

    addsub_accum_sequencer #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; FIFO pops are scored at the falling edge before the edge that pops.
    task automatic step();
        logic [6:0] got;
        logic [6:0] expv;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            got = {out_ovf, out_zero, out_carry, out_result};
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_entry got=%h exp=none", got);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    errors++;
                    $display("FAIL entry_%0d {ovf,zero,carry,res} got=%h exp=%h", pops, got, expv);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rand_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_push(input logic [1:0] op, input logic [3:0] b);
        int ua, ub, sa, sbv, r;
        logic [3:0] res;
        logic c, v;
        ua  = int'(m_acc);
        ub  = int'(b);
        sa  = m_acc[3] ? ua - 16 : ua;
        sbv = b[3] ? ub - 16 : ub;
        res = 4'h0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            LD: res = b;
            AD: begin
                r   = ua + ub;
                res = 4'(r);
                c   = (r > 15);
                v   = ((sa + sbv) > 7) || ((sa + sbv) < -8);
            end
            SB: begin
                r   = ua - ub;
                res = 4'(r);
                c   = (ua >= ub);
                v   = ((sa - sbv) > 7) || ((sa - sbv) < -8);
            end
            default: res = 4'h0;
        endcase
        exp_q.push_back({v, (res == 4'h0), c, res});
        m_acc = res;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] b);
        int n = 0;
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = b;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout op=%0d in_ready=%b exp=1", op, in_ready);
            in_valid = 1'b0;
            return;
        end
        model_push(op, b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_en   = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d out_valid=%b exp pending=0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        step();
        step();
        checks++;
        if ({acc, out_valid, in_ready, out_result, out_carry, out_ovf, out_zero} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got acc=%h ov=%b ir=%b res=%h c=%b v=%b z=%b exp all 0",
                     acc, out_valid, in_ready, out_result, out_carry, out_ovf, out_zero);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_reset_mid_exec();
        int p;
        send_cmd(LD, 4'h6);
        drain();
        checks++;
        if (acc !== 4'h6) begin
            errors++;
            $display("FAIL load6_acc got=%h exp=6", acc);
        end
        in_valid   = 1'b1;
        in_op      = AD;
        in_operand = 4'h3;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if ({acc, out_valid, in_ready} !== 6'h0) begin
            errors++;
            $display("FAIL reset_mid_exec got acc=%h ov=%b ir=%b exp 0 0 0", acc, out_valid, in_ready);
        end
        m_acc = 4'h0;
        step();
        rst = 1'b0;
        p   = pops;
        repeat (5) step();
        checks++;
        if (pops != p || out_valid !== 1'b0 || acc !== 4'h0) begin
            errors++;
            $display("FAIL dropped_cmd got pops=%0d ov=%b acc=%h exp pops=%0d ov=0 acc=0", pops, out_valid, acc, p);
        end
    endtask

    task automatic test_load_add();
        out_ready = 1'b1;
        send_cmd(LD, 4'h5);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_exec got=%b exp=0", in_ready);
        end
        send_cmd(AD, 4'h3);
        drain();
        checks++;
        if (acc !== 4'h8) begin
            errors++;
            $display("FAIL load_add_acc got=%h exp=8", acc);
        end
    endtask

    task automatic test_wrap();
        send_cmd(LD, 4'hF);
        send_cmd(AD, 4'h1);
        send_cmd(SB, 4'h1);
        drain();
        checks++;
        if (acc !== 4'hF) begin
            errors++;
            $display("FAIL wrap_acc got=%h exp=f", acc);
        end
    endtask

    task automatic test_sub_clear();
        send_cmd(LD, 4'h8);
        send_cmd(SB, 4'h1);
        send_cmd(CL, 4'h9);
        drain();
        checks++;
        if (acc !== 4'h0) begin
            errors++;
            $display("FAIL clear_acc got=%h exp=0", acc);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_cmd(LD, 4'h1);
        send_cmd(AD, 4'h2);
        step();
        in_valid   = 1'b1;
        in_op      = SB;
        in_operand = 4'h1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_ready_%0d got=%b exp=0", i, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_pop got=%b exp=1", in_ready);
        end
        send_cmd(SB, 4'h1);
        drain();
        checks++;
        if (acc !== 4'h2) begin
            errors++;
            $display("FAIL backpressure_acc got=%h exp=2", acc);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_cmd(LD, 4'h4);
        step();
        send_cmd(AD, 4'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (dut.u_fifo.count !== 2'd1) begin
            errors++;
            $display("FAIL pushpop_count got=%0d exp=1", dut.u_fifo.count);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 4'h5) begin
            errors++;
            $display("FAIL pushpop_head got ov=%b res=%h exp ov=1 res=5", out_valid, out_result);
        end
        drain();
    endtask

    task automatic test_random();
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 1)) step();
        end
        drain();
        checks++;
        if (acc !== m_acc) begin
            errors++;
            $display("FAIL random_final_acc got=%h exp=%h", acc, m_acc);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        pops       = 0;
        rand_en    = 1'b0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_op      = 2'b00;
        in_operand = 4'h0;
        out_ready  = 1'b0;
        m_acc      = 4'h0;
        test_reset();
        test_reset_mid_exec();
        test_load_add();
        test_wrap();
        test_sub_clear();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
